// File: rtl/uart_cmd_frame_tx.sv
// uart_cmd_frame_tx: 8N1 UART transmitter for a latched 5-byte command frame
module uart_cmd_frame_tx #(
  parameter int DVSR = 22,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk40M,
  input  logic       nRst,
  input  logic       i_send,
  input  logic [7:0] i_cmd,
  input  logic [7:0] i_addrLsb,
  input  logic [7:0] i_addrMsb,
  input  logic [7:0] i_dataLsb,
  input  logic [7:0] i_dataMsb,
  output logic       o_busy,
  output logic       o_done,
  output logic       serialOut
);
  localparam int TW = $clog2(DVSR);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [1:0]    r_state;
  logic [TW-1:0] r_tcnt;
  logic [SW-1:0] r_scnt;
  logic [2:0]    r_bcnt, r_idx;
  logic [39:0]   r_shadow;
  logic          r_tx, r_busy, r_done;
  logic          w_tick, w_accept, w_last;
  assign w_tick   = r_tcnt == TW'(DVSR - 1);
  assign w_accept = i_send && !r_busy;
  assign w_last   = w_tick && r_scnt == SW'(OVERSAMPLE - 1);
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign serialOut = r_tx;
  // The 40-bit shadow is one shift chain: after a byte's 8 shifts the next byte sits at [7:0].
  always_ff @(posedge clk40M) begin
    if (!nRst) begin
      r_state  <= IDLE;
      r_tcnt   <= '0;
      r_scnt   <= '0;
      r_bcnt   <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_tcnt <= (w_accept || w_tick) ? '0 : r_tcnt + 1'b1;
      if (r_state != IDLE && w_tick) r_scnt <= w_last ? '0 : r_scnt + 1'b1;
      case (r_state)
        IDLE: if (w_accept) begin
          r_shadow <= {i_dataMsb, i_dataLsb, i_addrMsb, i_addrLsb, i_cmd};
          r_idx    <= '0;
          r_scnt   <= '0;
          r_bcnt   <= '0;
          r_tx     <= 1'b0;
          r_busy   <= 1'b1;
          r_state  <= START;
        end
        START: if (w_last) begin
          r_tx    <= r_shadow[0];
          r_state <= DATA;
        end
        DATA: if (w_last) begin
          r_shadow <= r_shadow >> 1;
          r_bcnt   <= r_bcnt + 1'b1;
          r_tx     <= r_bcnt == 3'd7 ? 1'b1 : r_shadow[1];
          r_state  <= r_bcnt == 3'd7 ? STOP : DATA;
        end
        default: if (w_last) begin
          r_idx   <= r_idx == 3'd4 ? r_idx : r_idx + 1'b1;
          r_tx    <= r_idx == 3'd4;
          r_done  <= r_idx == 3'd4;
          r_busy  <= r_idx != 3'd4;
          r_state <= r_idx == 3'd4 ? IDLE : START;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// tb_uart_cmd_frame_tx: randomized frame checks against an arithmetic line model and a behavioural UART decoder
`timescale 1ns/100ps
module tb_uart_cmd_frame_tx;
  localparam int BITC = 352;
  localparam int FRAME = 50 * BITC;
  logic clk40M = 1'b0, nRst = 1'b0, i_send = 1'b0;
  logic [7:0] i_cmd = '0, i_addrLsb = '0, i_addrMsb = '0, i_dataLsb = '0, i_dataMsb = '0;
  logic o_busy, o_done, serialOut;
  int checks = 0, failures = 0;
  bit rx_en = 1'b0;
  int rx_err = 0;
  logic [7:0] rx_q[$];
  logic [39:0] sent_q[$];

  always #12.5 clk40M = ~clk40M;

  uart_cmd_frame_tx dut (
    .clk40M(clk40M), .nRst(nRst), .i_send(i_send),
    .i_cmd(i_cmd), .i_addrLsb(i_addrLsb), .i_addrMsb(i_addrMsb),
    .i_dataLsb(i_dataLsb), .i_dataMsb(i_dataMsb),
    .o_busy(o_busy), .o_done(o_done), .serialOut(serialOut)
  );

  // Behavioural 8N1 receiver sampling each bit at its centre.
  initial forever begin
    logic [7:0] b;
    @(negedge clk40M);
    if (rx_en && serialOut === 1'b0) begin
      repeat (BITC / 2) @(negedge clk40M);
      if (serialOut !== 1'b0) rx_err++;
      for (int i = 0; i < 8; i++) begin
        repeat (BITC) @(negedge clk40M);
        b[i] = serialOut;
      end
      repeat (BITC) @(negedge clk40M);
      if (serialOut !== 1'b1) rx_err++;
      rx_q.push_back(b);
    end
  end

  // Expected line level k clocks after acceptance: 10-bit characters, byte 0 in f[7:0].
  function automatic logic exp_line(input logic [39:0] f, input int k);
    int n, p;
    n = k / BITC;
    p = n % 10;
    return p == 0 ? 1'b0 : p == 9 ? 1'b1 : f[(n / 10) * 8 + p - 1];
  endfunction

  task automatic drive(input logic [39:0] f);
    {i_dataMsb, i_dataLsb, i_addrMsb, i_addrLsb, i_cmd} = f;
  endtask

  task automatic run_frame(input string name, input logic [39:0] f, input bit hold,
                           input bit intrude, input int intrude_at);
    int line_bad = 0, busy_bad = 0, done_bad = 0, edge_bad = 0, first = -1;
    logic prev = 1'b1;
    drive(f);
    i_send = 1'b1;
    sent_q.push_back(f);
    @(posedge clk40M);
    @(negedge clk40M);
    for (int k = 0; k < FRAME; k++) begin
      if (serialOut !== exp_line(f, k)) begin
        line_bad++;
        if (first < 0) first = k;
      end
      if (o_busy !== 1'b1) busy_bad++;
      if (o_done !== 1'b0) done_bad++;
      if (serialOut !== prev && k % BITC != 0) edge_bad++;
      prev = serialOut;
      if (intrude && k == 1) drive(~f);
      i_send = hold || (intrude && k == intrude_at);
      @(negedge clk40M);
    end
    checks++;
    if (line_bad != 0) begin
      failures++;
      $display("FAIL %s line: %0d bad cycles (first at clock %0d), required 0", name, line_bad, first);
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL %s busy: low in %0d frame cycles, required 0", name, busy_bad);
    end
    checks++;
    if (done_bad != 0) begin
      failures++;
      $display("FAIL %s early_done: high in %0d frame cycles, required 0", name, done_bad);
    end
    checks++;
    if (edge_bad != 0) begin
      failures++;
      $display("FAIL %s edge_timing: %0d edges off the 352-clock grid, required 0", name, edge_bad);
    end
    checks++;
    if ({o_done, o_busy, serialOut} !== 3'b101) begin
      failures++;
      $display("FAIL %s done_at_17600: done/busy/line=%b, required 101", name, {o_done, o_busy, serialOut});
    end
  endtask

  task automatic watch_idle(input string name, input int n);
    int act = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk40M);
      if (serialOut !== 1'b1 || o_done !== 1'b0 || o_busy !== 1'b0) act++;
    end
    checks++;
    if (act != 0) begin
      failures++;
      $display("FAIL %s: %0d active cycles while idle, required 0", name, act);
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    repeat (3) @(posedge clk40M);
    @(negedge clk40M);
    checks++;
    if ({o_done, o_busy, serialOut} !== 3'b001) begin
      failures++;
      $display("FAIL reset_state: done/busy/line=%b, required 001", {o_done, o_busy, serialOut});
    end
    nRst = 1'b1;
    drive({$urandom, $urandom});
    i_send = 1'b1;
    @(posedge clk40M);
    @(negedge clk40M);
    i_send = 1'b0;
    repeat (3000) @(negedge clk40M);
    nRst = 1'b0;
    @(posedge clk40M);
    @(negedge clk40M);
    checks++;
    if ({o_done, o_busy, serialOut} !== 3'b001) begin
      failures++;
      $display("FAIL reset_mid_frame: done/busy/line=%b, required 001", {o_done, o_busy, serialOut});
    end
    repeat (2) @(negedge clk40M);
    nRst = 1'b1;
    watch_idle("reset_abandon", 2000);
  endtask

  task automatic test_single_frame();
    run_frame("single", 40'hABCD1234A5, 1'b0, 1'b0, 0);
  endtask

  task automatic test_busy_ignore();
    run_frame("busy_ignore", {$urandom, $urandom}, 1'b0, 1'b1, 4990 + int'($urandom_range(0, 20)));
    watch_idle("busy_ignore_no_queue", 1000);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_first", 40'h01AA55FF00, 1'b1, 1'b0, 0);
    run_frame("b2b_second", 40'h01AA55FF00, 1'b1, 1'b0, 0);
    i_send = 1'b0;
    watch_idle("b2b_stop", 500);
  endtask

  task automatic test_loopback(input int n0);
    int bad = 0;
    checks++;
    if (rx_q.size() - n0 != 5 * sent_q.size()) begin
      failures++;
      $display("FAIL loopback_count: %0d bytes decoded, required %0d", rx_q.size() - n0, 5 * sent_q.size());
    end
    for (int i = 0; i < sent_q.size() && n0 + 5 * i + 4 < rx_q.size(); i++) begin
      logic [39:0] got;
      got = {rx_q[n0 + 5 * i + 4], rx_q[n0 + 5 * i + 3], rx_q[n0 + 5 * i + 2], rx_q[n0 + 5 * i + 1], rx_q[n0 + 5 * i]};
      checks++;
      if (got !== sent_q[i]) begin
        failures++;
        bad++;
        $display("FAIL loopback_frame%0d: cmd=%h addr=%h data=%h, required cmd=%h addr=%h data=%h",
                 i, got[7:0], got[23:8], got[39:24], sent_q[i][7:0], sent_q[i][23:8], sent_q[i][39:24]);
      end
    end
    checks++;
    if (rx_err != 0) begin
      failures++;
      $display("FAIL loopback_framing: %0d start/stop errors, required 0", rx_err);
    end
  endtask

  initial begin
    int n0;
    test_reset();
    sent_q.delete();
    rx_en = 1'b1;
    n0 = rx_q.size();
    test_single_frame();
    test_busy_ignore();
    test_back_to_back();
    test_loopback(n0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
